// File: rtl/fip_32_to_float.sv
// fip_32_to_float
//   Converts a signed Q(32-FRA_BITS).FRA_BITS fixed-point word into an
//   IEEE-754 single-precision float. It takes the magnitude, then shifts it
//   left one bit per cycle until the MSB is set, then rounds the result to
//   nearest with ties to even and packs it.
//
// Ports
//   i_clk    system clock
//   i_rstn   synchronous active-low reset; aborts any conversion in flight
//   i_en     start strobe, sampled only while idle
//   i_x      signed fixed-point operand, sampled on the accepting edge
//   o_z      float result {sign, exp[7:0], frac[22:0]}, held until the next o_valid
//   o_busy   high while a conversion is in flight
//   o_valid  one-cycle pulse when o_z holds a new result
module fip_32_to_float #(
  parameter int unsigned FRA_BITS = 16
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_en,
  input  logic [31:0] i_x,
  output logic [31:0] o_z,
  output logic        o_busy,
  output logic        o_valid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    PACK = 2'd2
  } state_e;

  // The exponent of a magnitude whose MSB sits at bit 31 after lz shifts is
  // (31 - lz) - FRA_BITS + 127. This folds the constant terms together.
  localparam logic [8:0] EXP_BASE = 9'(158 - FRA_BITS);

  state_e      state_q, state_d;
  logic        sign_q, sign_d;
  logic [31:0] mag_q, mag_d;
  logic [4:0]  lz_q, lz_d;
  logic [31:0] z_q, z_d;
  logic        busy_q, busy_d;
  logic        valid_q, valid_d;

  logic [8:0]  exp_s;
  logic        round_up_s;
  logic [30:0] em_rnd_s;

  // Rounding and packing of the normalised magnitude (used only in PACK).
  always_comb begin
    exp_s      = EXP_BASE - {4'd0, lz_q};
    // Guard bit set, and either a sticky bit or an odd LSB: ties go to even.
    round_up_s = mag_q[7] & ((|mag_q[6:0]) | mag_q[8]);
    // Adding across the whole {exp, mant} field means an all-ones mantissa
    // wraps to zero and its carry bumps the exponent.
    em_rnd_s   = {exp_s[7:0], mag_q[30:8]} + {30'd0, round_up_s};
  end

  // Next-state and datapath updates for the IDLE/NORM/PACK sequencer.
  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    mag_d   = mag_q;
    lz_d    = lz_q;
    z_d     = z_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_en) begin
          sign_d  = i_x[31];
          // Two's-complement negate. 0x80000000 maps onto itself, and read as
          // unsigned that is exactly its magnitude.
          mag_d   = i_x[31] ? (~i_x + 32'd1) : i_x;
          lz_d    = 5'd0;
          busy_d  = 1'b1;
          state_d = NORM;
        end else begin
          state_d = IDLE;
        end
      end
      NORM: begin
        if (mag_q == 32'd0) begin
          // Zero always encodes as +0. The sign is dropped.
          z_d     = 32'd0;
          valid_d = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (!mag_q[31]) begin
          mag_d   = {mag_q[30:0], 1'b0};
          lz_d    = lz_q + 5'd1;
          state_d = NORM;
        end else begin
          state_d = PACK;
        end
      end
      PACK: begin
        z_d     = {sign_q, em_rnd_s};
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      mag_q   <= 32'd0;
      lz_q    <= 5'd0;
      z_q     <= 32'd0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      mag_q   <= mag_d;
      lz_q    <= lz_d;
      z_q     <= z_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign o_z     = z_q;
  assign o_busy  = busy_q;
  assign o_valid = valid_q;

endmodule

// File: tb/tb_fip_32_to_float.sv
// tb_fip_32_to_float
//   Drives directed and random fixed-point operands into fip_32_to_float and
//   compares results and latencies against an arithmetic reference model.
//   It also covers the handshake corner cases and reset in mid-conversion.
module tb_fip_32_to_float;

  localparam int FRA = 16;

  logic        clk;
  logic        rstn;
  logic        en;
  logic [31:0] x;
  logic [31:0] z;
  logic        busy;
  logic        valid;

  int n_checks = 0;
  int n_errors = 0;

  fip_32_to_float #(.FRA_BITS(FRA)) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .i_en   (en),
    .i_x    (x),
    .o_z    (z),
    .o_busy (busy),
    .o_valid(valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Index of the highest set bit of a nonzero magnitude.
  function automatic int msb_pos(input longint a);
    int p;
    p = 0;
    for (int i = 0; i < 33; i++) begin
      if (a >= (64'sd1 <<< i)) p = i;
    end
    return p;
  endfunction

  // Reference: value = x / 2^FRA. Scale the magnitude to a 24-bit significand
  // and round it to nearest-even using integer division.
  function automatic logic [31:0] ref_float(input logic [31:0] xin);
    longint v, a, q, r, half;
    int     p, sh, e;
    logic   s;
    logic [7:0] e8;
    logic [22:0] f23;
    v = longint'($signed(xin));
    s = (v < 0);
    a = s ? -v : v;
    if (a == 0) return 32'd0;
    p = msb_pos(a);
    if (p >= 23) begin
      sh   = p - 23;
      q    = a / (64'sd1 <<< sh);
      r    = a - q * (64'sd1 <<< sh);
      half = (sh == 0) ? 64'sd0 : (64'sd1 <<< (sh - 1));
      if (sh > 0 && (r > half || (r == half && q[0]))) q = q + 64'sd1;
    end else begin
      q = a * (64'sd1 <<< (23 - p));
    end
    e = p + 127 - FRA;
    if (q == (64'sd1 <<< 24)) begin
      q = q / 64'sd2;
      e = e + 1;
    end
    e8  = e[7:0];
    f23 = q[22:0];
    return {s, e8, f23};
  endfunction

  // Edges from acceptance to the edge that raises o_valid.
  function automatic int ref_latency(input logic [31:0] xin);
    longint v, a;
    v = longint'($signed(xin));
    a = (v < 0) ? -v : v;
    if (a == 0) return 1;
    return 33 - msb_pos(a);
  endfunction

  // One conversion: accept, check busy, wait (bounded) for valid, check the
  // result, the latency and the return to idle.
  task automatic convert(input string tag, input logic [31:0] xin,
                         input logic [31:0] exp_z, input int exp_lat);
    int n;
    @(negedge clk);
    en = 1'b1;
    x  = xin;
    @(posedge clk);
    #1;
    en = 1'b0;
    x  = $urandom;
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    n = 0;
    while (!valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_z"}, z, exp_z);
    check({tag, "_lat"}, n, exp_lat);
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, {30'd0, valid, busy}, 32'd0);
  endtask

  logic [31:0] dir_x   [9] = '{32'h00010000, 32'hFFFE0000, 32'h00000001,
                               32'h80000000, 32'h7FFFFFFF, 32'h40000040,
                               32'h400000C0, 32'h00000000, 32'hFFFFFFFF};
  logic [31:0] dir_z   [9] = '{32'h3F800000, 32'hC0000000, 32'h37800000,
                               32'hC7000000, 32'h47000000, 32'h46800000,
                               32'h46800002, 32'h00000000, 32'hB7800000};
  int          dir_lat [9] = '{17, 16, 33, 2, 3, 3, 3, 1, 33};

  initial begin
    logic [31:0] rx;
    int nv, n;
    logic prev;

    rstn = 1'b0;
    en   = 1'b0;
    x    = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", {z[31:0]}, 32'd0);
    check("reset_ctl", {30'd0, valid, busy}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 9; i++) begin
      convert($sformatf("dir%0d", i), dir_x[i], dir_z[i], dir_lat[i]);
    end

    for (int i = 0; i < 150; i++) begin
      rx = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) rx = -rx;
      convert($sformatf("rnd%0d", i), rx, ref_float(rx), ref_latency(rx));
    end

    // A request while busy is dropped; only one result appears.
    @(negedge clk);
    en = 1'b1;
    x  = 32'h00010000;
    @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    en = 1'b1;
    x  = 32'h00020000;
    @(negedge clk);
    en = 1'b0;
    nv = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (valid) begin
        nv++;
        check("drop_z", z, 32'h3F800000);
      end
    end
    check("drop_count", nv, 1);

    // i_en held high: back-to-back conversions, each preceded by one idle
    // accept cycle.
    @(negedge clk);
    en   = 1'b1;
    x    = 32'h00010000;
    nv   = 0;
    prev = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1;
      if (valid) begin
        nv++;
        check("b2b_z", z, 32'h3F800000);
        check("b2b_gap", {31'd0, prev}, 32'd0);
      end
      prev = valid;
    end
    check("b2b_count", nv, 4);
    @(negedge clk);
    en = 1'b0;
    n  = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("b2b_drain", {31'd0, busy}, 32'd0);

    // Reset five cycles into a long conversion.
    @(negedge clk);
    en = 1'b1;
    x  = 32'h00000001;
    @(posedge clk);
    #1;
    en = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_z", z, 32'd0);
    check("rst_mid_ctl", {30'd0, valid, busy}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    nv = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (valid) nv++;
    end
    check("rst_mid_novalid", nv, 0);
    convert("after_rst", 32'h00010000, 32'h3F800000, 17);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fip_32_to_float.md
Name: fip_32_to_float

Overview:
- Sequential converter from signed Q(32-FRA_BITS).FRA_BITS fixed-point to IEEE-754 single-precision float.
- This is the return direction of the float-to-fixed ingest path. It converts raytracer results (hit distances, barycentrics, normals) from the fip_32 datapath into float words for the host readback path.
- Normalisation is iterative: one bit shift per cycle. The block uses the fip_32 en/valid/busy handshake.

Parameters:
- FRA_BITS, 16, fractional bit count of the input format. Legal range 0..31.

Ports:
- i_clk  input  1  system clock
- i_rstn  input  1  synchronous active-low reset
- i_en  input  1  start strobe; the input is sampled on a rising edge while idle
- i_x  input  32  signed fixed-point operand
- o_z  output  32  IEEE-754 single result: {sign, exp[7:0], frac[22:0]}
- o_busy  output  1  high while a conversion is in flight
- o_valid  output  1  one-cycle pulse when o_z holds a new result

Behaviour:
- Interface: one clock (i_clk); reset i_rstn is synchronous and active-low.
- Reset (i_rstn=0 at a rising edge):
  - state=IDLE; o_z=0, o_busy=0, o_valid=0.
  - Any conversion in flight is aborted and no valid is produced.
- States: IDLE, NORM, PACK.
- IDLE:
  - If i_en=1 at the edge, capture sign=i_x[31] and mag=|i_x| as a 32-bit unsigned value. FIP_MIN 0x80000000 gives mag=0x80000000 with no overflow.
  - Clear the shift counter lz, set o_busy=1, and go to NORM.
- NORM:
  - If mag==0: register o_z=0x00000000 (+0, sign dropped), pulse o_valid, clear o_busy, go to IDLE.
  - Else if mag[31]==0: mag<<=1, lz+=1, stay in NORM.
  - Else: go to PACK.
- PACK:
  - Biased exponent e = 158 - FRA_BITS - lz.
  - Mantissa m = mag[30:8], guard g = mag[7], sticky s = |mag[6:0].
  - Round to nearest, ties to even: increment m when g & (s | m[0]).
  - If the increment carries out of m (m was all ones): m=0, e+=1.
  - Register o_z = {sign, e[7:0], m}, pulse o_valid, clear o_busy, go to IDLE.
- Range: every input is representable, so there is no inf/NaN/denormal output. The exponent never overflows for legal FRA_BITS.
- Latency, counted from the accepting edge T0:
  - Nonzero input: o_valid is high in the cycle after edge T0+lz+2, where lz is the leading-zero count of mag.
  - Zero input: o_valid is high after edge T0+1.
  - Maximum: lz=31, 33 edges.
- Handshake:
  - i_en while o_busy=1 is ignored; no queueing, no corruption of the in-flight result.
  - i_en in the same cycle that o_valid is asserted is accepted, because the state is IDLE at that edge.
  - i_x only needs to be stable at the accepting edge.
- o_z holds the last result until the next o_valid. o_valid is never high for two consecutive cycles.

Test Plan (FRA_BITS=16):
- Basic values:
  - i_x=0x00010000 (1.0) -> o_z=0x3F800000; valid 17 edges after accept (lz=15).
  - i_x=0xFFFE0000 (-2.0) -> o_z=0xC0000000.
  - i_x=0x00000001 -> o_z=0x37800000 (2^-16); lz=31, valid after 33 edges.
- Extremes:
  - i_x=0x80000000 (FIP_MIN) -> o_z=0xC7000000 (-32768.0); lz=0.
  - i_x=0x7FFFFFFF (FIP_MAX) -> rounding carry -> o_z=0x47000000 (32768.0).
- Ties to even:
  - i_x=0x40000040 -> tie with even LSB, round down -> o_z=0x46800000.
  - i_x=0x400000C0 -> tie with odd LSB, round up -> o_z=0x46800002.
- Zero: i_x=0 -> o_z=0x00000000; valid after 1 edge. Then i_x=0xFFFFFFFF -> o_z=0xB7800000.
- Handshake:
  - Start 0x00010000, then pulse i_en with i_x=0x00020000 while busy -> single valid with 0x3F800000. The second request is dropped.
  - i_en held high continuously -> back-to-back conversions, o_valid pulses separated by at least one low cycle.
- Reset mid-operation: deassert i_rstn 5 cycles into converting 0x00000001 -> o_z=0, o_busy=0 and no o_valid. The next conversion of 0x00010000 is correct.
